// File: rtl/bsg_bladerunner_rom_ctrl.sv
// bsg_bladerunner_rom_ctrl
//   Shares one combinational configuration ROM among num_req_p requesters.
//   Requesters are granted round-robin. Each accepted read returns through a
//   registered valid/yumi response port, tagged with the requester id. A dump
//   mode streams every valid ROM word in address order.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_v_i/req_addr_i      per-requester request; address slice i is requester i
//   req_ready_o             one-hot grant (accept = req_v_i & req_ready_o)
//   dump_v_i/dump_busy_o    start a full-ROM dump (sampled in IDLE) / dump active
//   rom_addr_o/rom_data_i   combinational ROM interface
//   resp_*_o, resp_yumi_i   response word, id, range error, last dump word, consume
module bsg_bladerunner_rom_ctrl #(
   parameter  int width_p      = 32,
   parameter  int addr_width_p = 5,
   parameter  int rom_els_p    = 20,
   parameter  int num_req_p    = 2,
   localparam int id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [num_req_p-1:0]              req_v_i,
   input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
   output logic [num_req_p-1:0]              req_ready_o,
   input  logic                              dump_v_i,
   output logic                              dump_busy_o,
   output logic [addr_width_p-1:0]           rom_addr_o,
   input  logic [width_p-1:0]                rom_data_i,
   output logic                              resp_v_o,
   output logic [width_p-1:0]                resp_data_o,
   output logic [id_width_lp-1:0]            resp_id_o,
   output logic                              resp_err_o,
   output logic                              resp_last_o,
   input  logic                              resp_yumi_i
);

   typedef enum logic [1:0] {IDLE, RESP, DUMP} state_e;

   state_e                   state_q, state_d;
   logic [id_width_lp-1:0]   rr_q, rr_d;
   logic [addr_width_p-1:0]  dump_cnt_q, dump_cnt_d;
   logic [width_p-1:0]       data_q, data_d;
   logic [id_width_lp-1:0]   id_q, id_d;
   logic                     err_q, err_d;

   // unpack the flat address bus into one entry per requester
   logic [num_req_p-1:0][addr_width_p-1:0] addr_a;
   for (genvar i = 0; i < num_req_p; i++) begin : g_addr
      assign addr_a[i] = req_addr_i[i*addr_width_p +: addr_width_p];
   end

   // round-robin: first pass looks at requesters >= rr_q, second pass wraps
   logic                   found;
   logic [id_width_lp-1:0] win_id;
   always_comb begin
      found  = 1'b0;
      win_id = '0;
      for (int i = 0; i < num_req_p; i++)
         if (!found && req_v_i[i] && (i >= int'(rr_q))) begin
            found  = 1'b1;
            win_id = id_width_lp'(i);
         end
      for (int i = 0; i < num_req_p; i++)
         if (!found && req_v_i[i]) begin
            found  = 1'b1;
            win_id = id_width_lp'(i);
         end
   end

   logic [num_req_p-1:0]    grant_oh;
   always_comb begin
      grant_oh = '0;
      for (int i = 0; i < num_req_p; i++)
         grant_oh[i] = found && (win_id == id_width_lp'(i));
   end

   logic [addr_width_p-1:0] win_addr;
   logic                    in_range;
   logic                    dump_last;
   assign win_addr  = found ? addr_a[win_id] : '0;
   // one extra bit so rom_els_p == 2**addr_width_p still compares correctly
   assign in_range  = {1'b0, win_addr} < (addr_width_p+1)'(rom_els_p);
   assign dump_last = (dump_cnt_q == addr_width_p'(rom_els_p-1));

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      dump_cnt_d  = dump_cnt_q;
      data_d      = data_q;
      id_d        = id_q;
      err_d       = err_q;
      req_ready_o = '0;
      dump_busy_o = 1'b0;
      rom_addr_o  = '0;
      resp_v_o    = 1'b0;
      resp_data_o = '0;
      resp_id_o   = '0;
      resp_err_o  = 1'b0;
      resp_last_o = 1'b0;
      if (!reset_i) begin
         unique case (state_q)
            IDLE: begin
               rom_addr_o = win_addr;
               if (dump_v_i) begin
                  // dump takes priority over any simultaneous request
                  state_d    = DUMP;
                  dump_cnt_d = '0;
               end else if (found) begin
                  req_ready_o = grant_oh;
                  data_d      = in_range ? rom_data_i : '0;
                  err_d       = !in_range;
                  id_d        = win_id;
                  rr_d        = (win_id == id_width_lp'(num_req_p-1)) ? '0 : win_id + 1'b1;
                  state_d     = RESP;
               end
            end
            RESP: begin
               resp_v_o    = 1'b1;
               resp_data_o = data_q;
               resp_id_o   = id_q;
               resp_err_o  = err_q;
               if (resp_yumi_i) state_d = IDLE;
            end
            DUMP: begin
               dump_busy_o = 1'b1;
               rom_addr_o  = dump_cnt_q;
               resp_v_o    = 1'b1;
               resp_data_o = rom_data_i;
               resp_last_o = dump_last;
               if (resp_yumi_i) begin
                  if (dump_last) begin
                     dump_cnt_d = '0;
                     state_d    = IDLE;
                  end else begin
                     dump_cnt_d = dump_cnt_q + 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         dump_cnt_q <= '0;
         data_q     <= '0;
         id_q       <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         dump_cnt_q <= dump_cnt_d;
         data_q     <= data_d;
         id_q       <= id_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_bsg_bladerunner_rom_ctrl.sv
// Directed bench for bsg_bladerunner_rom_ctrl with a behavioural ROM attached.
module tb_bsg_bladerunner_rom_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_v;
   logic [4:0]  addr0, addr1;
   logic [9:0]  req_addr;
   logic [1:0]  req_ready;
   logic        dump_v, dump_busy;
   logic [4:0]  rom_addr;
   logic [31:0] rom_data;
   logic        resp_v, resp_err, resp_last, yumi;
   logic [31:0] resp_data;
   logic [0:0]  resp_id;

   int cmp = 0;
   int err = 0;

   logic [31:0] rom [0:31];

   always #5 clk = ~clk;
   assign req_addr = {addr1, addr0};
   assign rom_data = rom[rom_addr];

   bsg_bladerunner_rom_ctrl dut (
      .clk_i(clk), .reset_i(reset), .req_v_i(req_v), .req_addr_i(req_addr),
      .req_ready_o(req_ready), .dump_v_i(dump_v), .dump_busy_o(dump_busy),
      .rom_addr_o(rom_addr), .rom_data_i(rom_data), .resp_v_o(resp_v),
      .resp_data_o(resp_data), .resp_id_o(resp_id), .resp_err_o(resp_err),
      .resp_last_o(resp_last), .resp_yumi_i(yumi)
   );

   always @(posedge clk)
      assert (reset || !yumi || resp_v) else $error("yumi asserted without resp_v");

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_v = 2'b11; addr0 = 5'd0; addr1 = 5'd0; dump_v = 1'b0; yumi = 1'b0;
      tick(); tick(); tick();
      cmp++; if (req_ready !== 2'b00) begin err++; $display("FAIL reset_ready got %b exp 00", req_ready); end
      cmp++; if (resp_v !== 1'b0) begin err++; $display("FAIL reset_resp_v got %b exp 0", resp_v); end
      cmp++; if (dump_busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b exp 0", dump_busy); end
      cmp++; if (resp_data !== 32'h0 || resp_id !== 1'b0 || resp_err !== 1'b0 || resp_last !== 1'b0) begin
         err++; $display("FAIL reset_resp got %h/%b/%b/%b exp 0/0/0/0", resp_data, resp_id, resp_err, resp_last); end
      req_v = 2'b00;
      reset = 1'b0; #1;
   endtask

   task automatic test_single();
      req_v = 2'b01; addr0 = 5'd0; #1;
      cmp++; if (req_ready !== 2'b01) begin err++; $display("FAIL single_ready got %b exp 01", req_ready); end
      tick(); req_v = 2'b00; #1;
      cmp++; if (resp_v !== 1'b1) begin err++; $display("FAIL single_resp_v got %b exp 1", resp_v); end
      cmp++; if (resp_data !== 32'h00030602) begin err++; $display("FAIL single_data got %h exp 00030602", resp_data); end
      cmp++; if (resp_id !== 1'b0 || resp_err !== 1'b0) begin err++; $display("FAIL single_id_err got %b/%b exp 0/0", resp_id, resp_err); end
      yumi = 1'b1; tick(); yumi = 1'b0; #1;
      cmp++; if (resp_v !== 1'b0) begin err++; $display("FAIL single_idle got %b exp 0", resp_v); end
   endtask

   task automatic test_contention();
      logic [31:0] exp_d;
      logic [1:0]  exp_g;
      // reset first so the round-robin pointer starts at requester 0
      reset = 1'b1; tick(); reset = 1'b0;
      req_v = 2'b11; addr0 = 5'd9; addr1 = 5'd1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if ((i % 4) < 2) begin exp_g = 2'b01; exp_d = 32'h07EC9D3E; end
         else             begin exp_g = 2'b10; exp_d = 32'h05012020; end
         if (i % 2 == 0) begin
            cmp++; if (req_ready !== exp_g || resp_v !== 1'b0) begin
               err++; $display("FAIL cont_grant%0d got %b/%b exp %b/0", i, req_ready, resp_v, exp_g); end
            yumi = 1'b0;
         end else begin
            cmp++; if (resp_v !== 1'b1 || resp_data !== exp_d || resp_id !== exp_g[1]) begin
               err++; $display("FAIL cont_resp%0d got %b/%h/%b exp 1/%h/%b", i, resp_v, resp_data, resp_id, exp_d, exp_g[1]); end
            yumi = 1'b1;
         end
         tick();
      end
      req_v = 2'b00; yumi = 1'b0; #1;
   endtask

   task automatic test_out_of_range();
      req_v = 2'b10; addr1 = 5'd25; #1;
      cmp++; if (req_ready !== 2'b10) begin err++; $display("FAIL oor_ready got %b exp 10", req_ready); end
      tick(); req_v = 2'b00; #1;
      cmp++; if (resp_v !== 1'b1 || resp_err !== 1'b1 || resp_data !== 32'h0 || resp_id !== 1'b1) begin
         err++; $display("FAIL oor_resp got v%b e%b %h id%b exp v1 e1 00000000 id1", resp_v, resp_err, resp_data, resp_id); end
      yumi = 1'b1; tick(); yumi = 1'b0; #1;
   endtask

   task automatic test_backpressure_resp();
      req_v = 2'b01; addr0 = 5'd1; tick();
      req_v = 2'b11;
      for (int i = 0; i < 5; i++) begin
         #1;
         cmp++; if (resp_v !== 1'b1 || resp_data !== 32'h05012020 || resp_id !== 1'b0 || req_ready !== 2'b00) begin
            err++; $display("FAIL bp_resp%0d got v%b %h id%b rdy%b exp v1 05012020 id0 rdy00", i, resp_v, resp_data, resp_id, req_ready); end
         tick();
      end
      req_v = 2'b00; yumi = 1'b1; tick(); yumi = 1'b0; #1;
   endtask

   task automatic test_dump();
      req_v = 2'b01; addr0 = 5'd0; dump_v = 1'b1; #1;
      cmp++; if (req_ready !== 2'b00) begin err++; $display("FAIL dump_start_ready got %b exp 00", req_ready); end
      tick(); dump_v = 1'b0;
      for (int w = 0; w < 20; w++) begin
         #1;
         cmp++; if (dump_busy !== 1'b1 || resp_v !== 1'b1 || resp_data !== rom[w] || resp_last !== (w == 19) ||
                    req_ready !== 2'b00 || resp_id !== 1'b0 || resp_err !== 1'b0) begin
            err++; $display("FAIL dump_w%0d got b%b v%b %h l%b rdy%b exp b1 v1 %h l%b rdy00", w, dump_busy, resp_v, resp_data, resp_last, req_ready, rom[w], (w == 19)); end
         if (w == 5) begin
            yumi = 1'b0;
            for (int s = 0; s < 5; s++) begin
               tick();
               cmp++; if (rom_addr !== 5'd5 || resp_data !== rom[5] || dump_busy !== 1'b1 || req_ready !== 2'b00) begin
                  err++; $display("FAIL dump_bp%0d got a%0d %h rdy%b exp a5 %h rdy00", s, rom_addr, resp_data, req_ready, rom[5]); end
            end
         end
         yumi = 1'b1; tick(); yumi = 1'b0;
      end
      #1;
      cmp++; if (dump_busy !== 1'b0 || resp_v !== 1'b0 || req_ready !== 2'b01) begin
         err++; $display("FAIL dump_end got b%b v%b rdy%b exp b0 v0 rdy01", dump_busy, resp_v, req_ready); end
      tick(); req_v = 2'b00; #1;
      cmp++; if (resp_v !== 1'b1 || resp_data !== 32'h00030602) begin
         err++; $display("FAIL dump_pending got v%b %h exp v1 00030602", resp_v, resp_data); end
      yumi = 1'b1; tick(); yumi = 1'b0; #1;
   endtask

   task automatic test_reset_mid_dump();
      dump_v = 1'b1; tick(); dump_v = 1'b0;
      for (int w = 0; w < 7; w++) begin yumi = 1'b1; tick(); end
      yumi = 1'b0; #1;
      cmp++; if (rom_addr !== 5'd7 || resp_data !== rom[7]) begin
         err++; $display("FAIL mid_w7 got a%0d %h exp a7 %h", rom_addr, resp_data, rom[7]); end
      reset = 1'b1; tick(); reset = 1'b0; #1;
      cmp++; if (resp_v !== 1'b0 || dump_busy !== 1'b0) begin
         err++; $display("FAIL mid_reset got v%b b%b exp v0 b0", resp_v, dump_busy); end
      // last grant before reset was requester 0, so a cleared pointer must pick 0 again
      req_v = 2'b11; #1;
      cmp++; if (req_ready !== 2'b01) begin err++; $display("FAIL mid_rr got %b exp 01", req_ready); end
      req_v = 2'b00; dump_v = 1'b1; tick(); dump_v = 1'b0; #1;
      cmp++; if (rom_addr !== 5'd0 || resp_data !== 32'h00030602 || dump_busy !== 1'b1) begin
         err++; $display("FAIL redump got a%0d %h b%b exp a0 00030602 b1", rom_addr, resp_data, dump_busy); end
      for (int w = 0; w < 19; w++) begin yumi = 1'b1; tick(); end
      yumi = 1'b0; #1;
      cmp++; if (resp_last !== 1'b1 || resp_data !== 32'h000000C8) begin
         err++; $display("FAIL redump_last got l%b %h exp l1 000000c8", resp_last, resp_data); end
      yumi = 1'b1; tick(); yumi = 1'b0; #1;
      cmp++; if (dump_busy !== 1'b0) begin err++; $display("FAIL redump_done got %b exp 0", dump_busy); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rom[i] = (i < 20) ? (32'h1000_0000 + i) : (32'hDEAD_0000 + i);
      rom[0] = 32'h00030602; rom[1] = 32'h05012020; rom[9] = 32'h07EC9D3E; rom[19] = 32'h000000C8;
      test_reset();
      test_single();
      test_contention();
      test_out_of_range();
      test_backpressure_resp();
      test_dump();
      test_reset_mid_dump();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end

endmodule
